packet_detect_control: RTL and testbench

Sequencing controller for the packet-detection datapath. It consumes a joint sample stream carrying aligned outputs of two moving summations (windowed correlation magnitude and windowed power). It masks the window-fill warm-up, declares a detection after a plateau of consecutive threshold hits, and emits one timestamped event per packet. It then holds off re-triggering for a programmable number of samples. It sits between the moving-sum stage and the frame-synchronisation logic.

---
 rtl/packet_detect_control.sv | 146 ++++++++++++++
 tb/tb_packet_detect_control.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_detect_control.sv
// Packet-detection sequencing controller. Masks moving-sum warm-up, detects a
// plateau of consecutive threshold hits, emits one indexed event per packet,
// then holds off re-triggering for a programmable number of samples.
`timescale 1ns/1ps
module packet_detect_control #(
    parameter int WIDTH   = 36,
    parameter int FRAC    = 8,
    parameter int WARMUP  = 16,
    parameter int PLATEAU = 32,
    parameter int HOLDOFF = 320
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [FRAC-1:0]  threshold,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_corr,
    input  logic [WIDTH-1:0] s_power,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic             busy
);

    localparam int PW = WIDTH + FRAC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_SEARCH,
        ST_REPORT,
        ST_HOLDOFF
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] idx_q, idx_d;      // index of the next accepted sample
    logic [31:0] cnt_q, cnt_d;      // warm-up / holdoff sample counter
    logic [31:0] run_q, run_d;      // consecutive hits seen in SEARCH
    logic [31:0] m_data_q, m_data_d;

    logic [PW-1:0] corr_scaled;
    logic [PW-1:0] power_scaled;
    logic          hit;
    logic          accept;

    // Full-width ratio compare: corr / power >= threshold / 2^FRAC, without division.
    assign corr_scaled  = {s_corr, {FRAC{1'b0}}};
    assign power_scaled = PW'(s_power) * PW'(threshold);
    assign hit          = (s_power != '0) && (corr_scaled >= power_scaled);

    // Handshake outputs depend on state only, never on m_ready or s_valid.
    assign s_ready = (state_q != ST_REPORT);
    assign m_valid = (state_q == ST_REPORT);
    assign busy    = (state_q != ST_IDLE);
    assign m_data  = m_data_q;
    assign accept  = s_valid && s_ready;

    // Next-state and counter logic; disable overrides every other transition.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        m_data_d = m_data_q;

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_WARMUP;
                    idx_d   = '0;
                    cnt_d   = '0;
                    run_d   = '0;
                end
                ST_WARMUP: begin
                    if (accept) begin
                        idx_d = idx_q + 32'd1;
                        if (cnt_q == 32'(WARMUP - 1)) begin
                            cnt_d   = '0;
                            run_d   = '0;
                            state_d = ST_SEARCH;
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (accept) begin
                        idx_d = idx_q + 32'd1;
                        if (hit) begin
                            run_d = run_q + 32'd1;
                            if (run_q == 32'(PLATEAU - 1)) begin
                                m_data_d = idx_q;
                                state_d  = ST_REPORT;
                            end
                        end else begin
                            run_d = '0;
                        end
                    end
                end
                ST_REPORT: begin
                    if (m_ready) begin
                        run_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (accept) begin
                        idx_d = idx_q + 32'd1;
                        if (cnt_q == 32'(HOLDOFF - 1)) begin
                            cnt_d   = '0;
                            run_d   = '0;
                            state_d = ST_SEARCH;
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and counter registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            run_q    <= '0;
            m_data_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            m_data_q <= m_data_d;
        end
    end

endmodule

// File: tb/tb_packet_detect_control.sv
// Self-checking bench for packet_detect_control. A reference model keeps the
// per-session list of hit flags and finds events by scanning windows of it.
`timescale 1ns/1ps
module tb_packet_detect_control;

    localparam int WIDTH   = 36;
    localparam int FRAC    = 8;
    localparam int WARMUP  = 16;
    localparam int PLATEAU = 32;
    localparam int HOLDOFF = 320;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [FRAC-1:0]  threshold;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_corr;
    logic [WIDTH-1:0] s_power;
    logic             m_valid;
    logic             m_ready;
    logic [31:0]      m_data;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          mdl_active;
    bit          mdl_pend;
    int unsigned mdl_data;
    int          mdl_search;
    bit          mdl_hits[$];

    always #5 clk = ~clk;

    packet_detect_control #(
        .WIDTH(WIDTH), .FRAC(FRAC), .WARMUP(WARMUP), .PLATEAU(PLATEAU), .HOLDOFF(HOLDOFF)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .threshold(threshold),
        .s_valid(s_valid), .s_ready(s_ready), .s_corr(s_corr), .s_power(s_power),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
    );

    // Ratio rule from plain arithmetic: corr * 2^FRAC >= power * threshold, power nonzero.
    function automatic bit ref_hit(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] p,
                                   input logic [FRAC-1:0] t);
        longint unsigned lhs;
        longint unsigned rhs;
        lhs = longint'(c) * (64'd1 << FRAC);
        rhs = longint'(p) * longint'(t);
        return (p != 0) && (lhs >= rhs);
    endfunction

    // An event fires at index i when i is past the search start and the last
    // PLATEAU samples are all hits; the next search starts HOLDOFF samples later.
    function automatic void model_accept(input bit h);
        int idx;
        bit all_hit;
        idx = mdl_hits.size();
        mdl_hits.push_back(h);
        if (idx >= mdl_search + PLATEAU - 1) begin
            all_hit = 1'b1;
            for (int k = idx - PLATEAU + 1; k <= idx; k++)
                if (!mdl_hits[k]) all_hit = 1'b0;
            if (all_hit) begin
                mdl_pend   = 1'b1;
                mdl_data   = idx;
                mdl_search = idx + HOLDOFF + 1;
            end
        end
    endfunction

    // One clock: drive at negedge, update model, compare at following negedge.
    task automatic cycle(input bit en, input bit v, input logic [WIDTH-1:0] c,
                         input logic [WIDTH-1:0] p, input logic [FRAC-1:0] t, input bit mr);
        bit acc;
        bit h;
        enable = en; s_valid = v; s_corr = c; s_power = p; threshold = t; m_ready = mr;
        h = ref_hit(c, p, t);
        if (mdl_active) begin
            if (!en) begin
                mdl_active = 1'b0;
                mdl_pend   = 1'b0;
            end else begin
                acc = v && !mdl_pend;
                if (mdl_pend && mr) mdl_pend = 1'b0;
                if (acc) model_accept(h);
            end
        end else if (en) begin
            mdl_active = 1'b1;
            mdl_hits.delete();
            mdl_search = WARMUP;
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (m_valid !== mdl_pend) begin
            n_errors++;
            $display("FAIL m_valid at t=%0t: got %b expected %b", $time, m_valid, mdl_pend);
        end
        n_checks++;
        if (s_ready !== !mdl_pend) begin
            n_errors++;
            $display("FAIL s_ready at t=%0t: got %b expected %b", $time, s_ready, !mdl_pend);
        end
        n_checks++;
        if (busy !== mdl_active) begin
            n_errors++;
            $display("FAIL busy at t=%0t: got %b expected %b", $time, busy, mdl_active);
        end
        if (mdl_pend) begin
            n_checks++;
            if (m_data !== mdl_data) begin
                n_errors++;
                $display("FAIL m_data at t=%0t: got %0d expected %0d", $time, m_data, mdl_data);
            end
        end
    endtask

    // Drive samples with m_ready low until an event appears, bounded by max_cyc.
    task automatic wait_event(input string name, input logic [WIDTH-1:0] c,
                              input logic [WIDTH-1:0] p, input logic [FRAC-1:0] t,
                              input int max_cyc, output logic [31:0] got);
        bit seen;
        seen = 1'b0;
        got  = '1;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            cycle(1'b1, 1'b1, c, p, t, 1'b0);
            if (m_valid === 1'b1) begin
                seen = 1'b1;
                got  = m_data;
            end
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: got no event expected one within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic expect_event(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got m_data %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_corr = '0; s_power = '0;
        threshold = '0; m_ready = 1'b0;
        mdl_active = 1'b0; mdl_pend = 1'b0; mdl_data = 0; mdl_search = WARMUP;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({s_ready, m_valid, busy} !== 3'b100 || m_data !== 32'd0) begin
            n_errors++;
            $display("FAIL reset values: got s_ready=%b m_valid=%b busy=%b m_data=%0d expected 1 0 0 0",
                     s_ready, m_valid, busy, m_data);
        end
        reset = 1'b0;
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic test_warmup();
        logic [31:0] got;
        wait_event("warmup", 36'd60, 36'd100, 8'h80, 200, got);
        expect_event("warmup first event", got, 32'd47);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic test_broken_plateau();
        logic [31:0] got;
        cycle(1'b1, 1'b1, 36'd60, 36'd100, 8'h80, 1'b0);
        for (int i = 0; i < WARMUP + PLATEAU - 1; i++) cycle(1'b1, 1'b1, 36'd60, 36'd100, 8'h80, 1'b0);
        cycle(1'b1, 1'b1, 36'd40, 36'd100, 8'h80, 1'b0);
        wait_event("broken plateau", 36'd60, 36'd100, 8'h80, 100, got);
        expect_event("broken plateau event", got, 32'd79);
    endtask

    // Continues from the pending event of the broken-plateau scenario.
    task automatic test_back_pressure();
        logic [31:0] got;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 36'd60, 36'd100, 8'h80, 1'b0);
            n_checks++;
            if (s_ready !== 1'b0 || m_data !== 32'd79) begin
                n_errors++;
                $display("FAIL stall cycle %0d: got s_ready=%b m_data=%0d expected 0 79", i, s_ready, m_data);
            end
        end
        cycle(1'b1, 1'b1, 36'd60, 36'd100, 8'h80, 1'b1);
        n_checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL after handshake: got s_ready=%b m_valid=%b expected 1 0", s_ready, m_valid);
        end
        wait_event("holdoff", 36'd60, 36'd100, 8'h80, 400, got);
        expect_event("event after holdoff", got, 32'd79 + HOLDOFF + PLATEAU);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int unsigned seen[$];
        for (int i = 0; i < 800 && seen.size() < 3; i++) begin
            cycle(1'b1, 1'b1, 36'd60, 36'd100, 8'h80, 1'b1);
            if (m_valid === 1'b1) seen.push_back(m_data);
        end
        n_checks++;
        if (seen.size() != 3 || seen[0] != 47 || seen[1] != 399 || seen[2] != 751) begin
            n_errors++;
            $display("FAIL retrigger: got %0d events %p expected 47 399 751", seen.size(), seen);
        end
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic test_threshold_edges();
        logic [31:0] got;
        int early;
        early = 0;
        cycle(1'b1, 1'b1, 36'd60, 36'd100, 8'h80, 1'b0);
        for (int i = 0; i < WARMUP; i++) cycle(1'b1, 1'b1, 36'd60, 36'd100, 8'h80, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b1, 36'd0, 36'd0, 8'h80, 1'b0);
            if (m_valid === 1'b1) early++;
        end
        n_checks++;
        if (early != 0) begin
            n_errors++;
            $display("FAIL zero power: got %0d event cycles expected 0", early);
        end
        wait_event("zero threshold", 36'd0, 36'd1, 8'h00, 100, got);
        expect_event("zero threshold event", got, 32'd87);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);
        wait_event("equality", 36'd50, 36'd100, 8'h80, 200, got);
        expect_event("equality event", got, 32'd47);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic test_disable_reset();
        logic [31:0] got;
        wait_event("pre-disable", 36'd60, 36'd100, 8'h80, 200, got);
        expect_event("pre-disable event", got, 32'd47);
        cycle(1'b0, 1'b1, 36'd60, 36'd100, 8'h80, 1'b0);
        n_checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL disable in report: got m_valid=%b busy=%b expected 0 0", m_valid, busy);
        end
        for (int i = 0; i < 21; i++) cycle(1'b1, 1'b1, 36'd60, 36'd100, 8'h80, 1'b0);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({s_ready, m_valid, busy} !== 3'b100 || m_data !== 32'd0) begin
            n_errors++;
            $display("FAIL async reset: got s_ready=%b m_valid=%b busy=%b m_data=%0d expected 1 0 0 0",
                     s_ready, m_valid, busy, m_data);
        end
        mdl_active = 1'b0;
        mdl_pend   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        wait_event("after reset", 36'd60, 36'd100, 8'h80, 200, got);
        expect_event("index restart", got, 32'd47);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] c;
        logic [FRAC-1:0]  t;
        int sel;
        for (int i = 0; i < 4000; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 2) p = '0;
            else if (sel < 20) p = {4'($urandom_range(0, 15)), 32'($urandom)};
            else p = WIDTH'($urandom_range(1, 2000));
            t = FRAC'($urandom);
            sel = $urandom_range(0, 99);
            if (sel < 97) c = p;
            else if (sel < 99) c = WIDTH'((longint'(p) * longint'(t)) >> FRAC);
            else c = '0;
            cycle($urandom_range(0, 599) != 0, $urandom_range(0, 3) != 0, c, p, t,
                  $urandom_range(0, 1) == 1);
        end
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_broken_plateau();
        test_back_pressure();
        test_back_to_back();
        test_threshold_edges();
        test_disable_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
